// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB stage bus bundle: upstream slot, data-memory port and writeback slot.
// The slave modport is the memory stage's view; master is the surrounding pipeline/memory.
interface mem_stage_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   logic              MEM_Valid;
   logic [DATA_W-1:0] MEM_ALUResult;
   logic [DATA_W-1:0] MEM_D2;
   logic [REG_W-1:0]  MEM_RD;
   logic              MEM_RegWrite;
   logic              MEM_MemToReg;
   logic              MEM_MEM_WEN;
   logic              MEM_MEM_REN;

   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   logic              mem_stall;
   logic              WB_Valid;
   logic              WB_RegWrite;
   logic [REG_W-1:0]  WB_RD;
   logic [DATA_W-1:0] WB_WriteData;
   logic              mem_misalign;
   logic              bus_err;

   modport slave (
      input  MEM_Valid, MEM_ALUResult, MEM_D2, MEM_RD,
             MEM_RegWrite, MEM_MemToReg, MEM_MEM_WEN, MEM_MEM_REN,
             dmem_ack, dmem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
             mem_stall, WB_Valid, WB_RegWrite, WB_RD, WB_WriteData,
             mem_misalign, bus_err
   );

   modport master (
      output MEM_Valid, MEM_ALUResult, MEM_D2, MEM_RD,
             MEM_RegWrite, MEM_MemToReg, MEM_MEM_WEN, MEM_MEM_REN,
             dmem_ack, dmem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
             mem_stall, WB_Valid, WB_RegWrite, WB_RD, WB_WriteData,
             mem_misalign, bus_err
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one data-memory access per load/store, stalls upstream
// until ack or timeout, and produces the registered MEM/WB slot plus fault pulses.
module mem_stage #(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input logic        clock,
   input logic        reset,
   mem_stage_if.slave bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req;
   logic              r_we;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wb_valid;
   logic              r_wb_rw;
   logic [REG_W-1:0]  r_wb_rd;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_misalign;
   logic              r_bus_err;

   logic [0:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_req_nxt;
   logic              w_we_nxt;
   logic [DATA_W-1:0] w_addr_nxt;
   logic [DATA_W-1:0] w_wdata_nxt;
   logic              w_wb_valid_nxt;
   logic              w_wb_rw_nxt;
   logic [REG_W-1:0]  w_wb_rd_nxt;
   logic [DATA_W-1:0] w_wb_data_nxt;
   logic              w_misalign_nxt;
   logic              w_bus_err_nxt;
   logic              w_stall;

   logic              w_memop;
   logic              w_aligned;
   logic              w_rd_nz;
   logic              w_timeout;

   assign w_memop   = bus.MEM_Valid & (bus.MEM_MEM_WEN | bus.MEM_MEM_REN);
   assign w_aligned = (bus.MEM_ALUResult[1:0] == 2'b00);
   assign w_rd_nz   = (bus.MEM_RD != '0);
   assign w_timeout = (r_cnt == CNT_LAST);

   // Next-state and next-output logic; WB_Valid and fault pulses default low every cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_req_nxt      = r_req;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_wdata_nxt    = r_wdata;
      w_wb_valid_nxt = 1'b0;
      w_wb_rw_nxt    = 1'b0;
      w_wb_rd_nxt    = r_wb_rd;
      w_wb_data_nxt  = r_wb_data;
      w_misalign_nxt = 1'b0;
      w_bus_err_nxt  = 1'b0;
      w_stall        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.MEM_Valid && !w_memop) begin
               w_wb_valid_nxt = 1'b1;
               w_wb_rd_nxt    = bus.MEM_RD;
               w_wb_data_nxt  = bus.MEM_ALUResult;
               w_wb_rw_nxt    = bus.MEM_RegWrite & w_rd_nz;
            end else if (w_memop && !w_aligned) begin
               w_wb_valid_nxt = 1'b1;
               w_wb_rd_nxt    = bus.MEM_RD;
               w_wb_data_nxt  = bus.MEM_ALUResult;
               w_misalign_nxt = 1'b1;
            end else if (w_memop) begin
               // A simultaneous WEN/REN is treated as a write.
               w_stall     = 1'b1;
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = '0;
               w_req_nxt   = 1'b1;
               w_we_nxt    = bus.MEM_MEM_WEN;
               w_addr_nxt  = bus.MEM_ALUResult;
               w_wdata_nxt = bus.MEM_D2;
            end
         end
         ST_BUSY: begin
            if (bus.dmem_ack) begin
               w_state_nxt    = ST_IDLE;
               w_req_nxt      = 1'b0;
               w_wb_valid_nxt = 1'b1;
               w_wb_rd_nxt    = bus.MEM_RD;
               w_wb_data_nxt  = bus.MEM_MemToReg ? bus.dmem_rdata : bus.MEM_ALUResult;
               w_wb_rw_nxt    = bus.MEM_RegWrite & ~r_we & w_rd_nz;
            end else if (w_timeout) begin
               w_state_nxt    = ST_IDLE;
               w_req_nxt      = 1'b0;
               w_wb_valid_nxt = 1'b1;
               w_wb_rd_nxt    = bus.MEM_RD;
               w_wb_data_nxt  = bus.MEM_ALUResult;
               w_bus_err_nxt  = 1'b1;
            end else begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any in-flight access.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wb_valid <= 1'b0;
         r_wb_rw    <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_req      <= w_req_nxt;
         r_we       <= w_we_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_wb_valid <= w_wb_valid_nxt;
         r_wb_rw    <= w_wb_rw_nxt;
         r_wb_rd    <= w_wb_rd_nxt;
         r_wb_data  <= w_wb_data_nxt;
         r_misalign <= w_misalign_nxt;
         r_bus_err  <= w_bus_err_nxt;
      end
   end

   assign bus.dmem_req     = r_req;
   assign bus.dmem_we      = r_we;
   assign bus.dmem_addr    = r_addr;
   assign bus.dmem_wdata   = r_wdata;
   assign bus.mem_stall    = w_stall;
   assign bus.WB_Valid     = r_wb_valid;
   assign bus.WB_RegWrite  = r_wb_rw;
   assign bus.WB_RD        = r_wb_rd;
   assign bus.WB_WriteData = r_wb_data;
   assign bus.mem_misalign = r_misalign;
   assign bus.bus_err      = r_bus_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level expected results plus per-cycle compare.
module tb_mem_stage;
   localparam int unsigned T = 4;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mem_stage_if bus_if ();

   mem_stage #(.ACK_TIMEOUT(T)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        rw;
      logic        mis;
      logic        be;
      logic        chk_data;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic        exp_stall = 1'b0;
   logic        bus_active = 1'b0;
   logic        exp_we = 1'b0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_wdata = '0;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Per-cycle compare against the expected-result queue and expected bus/stall state.
   always @(negedge clock) begin
      exp_t e;
      logic exp_v;
      if (reset === 1'b1) begin
         exp_v = (q.size() > 0) && (q[0].due == cyc);
         chk("wb_valid", 32'(bus_if.WB_Valid), 32'(exp_v));
         chk("mem_stall", 32'(bus_if.mem_stall), 32'(exp_stall));
         chk("dmem_req", 32'(bus_if.dmem_req), 32'(bus_active));
         if (bus_active) begin
            chk("dmem_we", 32'(bus_if.dmem_we), 32'(exp_we));
            chk("dmem_addr", bus_if.dmem_addr, exp_addr);
            chk("dmem_wdata", bus_if.dmem_wdata, exp_wdata);
         end
         if (exp_v) begin
            e = q.pop_front();
            chk("wb_regwrite", 32'(bus_if.WB_RegWrite), 32'(e.rw));
            chk("mem_misalign", 32'(bus_if.mem_misalign), 32'(e.mis));
            chk("bus_err", 32'(bus_if.bus_err), 32'(e.be));
            if (e.chk_data) begin
               chk("wb_rd", 32'(bus_if.WB_RD), 32'(e.rd));
               chk("wb_data", bus_if.WB_WriteData, e.data);
            end
         end else begin
            chk("wb_regwrite_idle", 32'(bus_if.WB_RegWrite), 32'h0);
            chk("mem_misalign_idle", 32'(bus_if.mem_misalign), 32'h0);
            chk("bus_err_idle", 32'(bus_if.bus_err), 32'h0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Presents one valid instruction, plays the memory (ack after ack_dly BUSY cycles)
   // and queues the writeback the rules demand.
   task automatic run_op(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic wen, input logic ren,
                         input int ack_dly, input logic [31:0] rdata,
                         output int n_stall, output int n_req);
      exp_t e;
      logic memop;
      logic aligned;
      bit   done;
      memop   = wen | ren;
      aligned = (alu[1:0] == 2'b00);
      bus_if.MEM_Valid     = 1'b1;
      bus_if.MEM_ALUResult = alu;
      bus_if.MEM_D2        = d2;
      bus_if.MEM_RD        = rd;
      bus_if.MEM_RegWrite  = rw;
      bus_if.MEM_MemToReg  = m2r;
      bus_if.MEM_MEM_WEN   = wen;
      bus_if.MEM_MEM_REN   = ren;
      n_stall = 0;
      n_req   = 0;
      e.rd = rd; e.data = alu; e.rw = rw && (rd != 0);
      e.mis = 1'b0; e.be = 1'b0; e.chk_data = 1'b1; e.due = 0;
      exp_stall = memop && aligned;
      @(negedge clock);
      if (bus_if.mem_stall) n_stall++;
      if (bus_if.dmem_req) n_req++;
      @(posedge clock);
      #1;
      if (memop && !aligned) begin
         e.rw = 1'b0; e.mis = 1'b1; e.chk_data = 1'b0;
      end else if (memop) begin
         exp_we = wen; exp_addr = alu; exp_wdata = d2; bus_active = 1'b1;
         done = 1'b0;
         for (int b = 0; b < int'(T) && !done; b++) begin
            bus_if.dmem_ack   = (b == ack_dly);
            bus_if.dmem_rdata = (b == ack_dly) ? rdata : $urandom;
            exp_stall = (b != ack_dly) && (b != int'(T) - 1);
            @(negedge clock);
            if (bus_if.mem_stall) n_stall++;
            if (bus_if.dmem_req) n_req++;
            @(posedge clock);
            #1;
            bus_if.dmem_ack = 1'b0;
            if (b == ack_dly) begin
               e.data = m2r ? rdata : alu;
               e.rw   = rw && !wen && (rd != 0);
               done   = 1'b1;
            end else if (b == int'(T) - 1) begin
               e.rw = 1'b0; e.be = 1'b1; e.chk_data = 1'b0;
               done = 1'b1;
            end
         end
         bus_active = 1'b0;
      end
      exp_stall = 1'b0;
      bus_if.MEM_Valid   = 1'b0;
      bus_if.MEM_MEM_WEN = 1'b0;
      bus_if.MEM_MEM_REN = 1'b0;
      e.due = cyc;
      q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_dmem_req"}, 32'(bus_if.dmem_req), 32'h0);
      chk({tag, "_dmem_we"}, 32'(bus_if.dmem_we), 32'h0);
      chk({tag, "_dmem_addr"}, bus_if.dmem_addr, 32'h0);
      chk({tag, "_dmem_wdata"}, bus_if.dmem_wdata, 32'h0);
      chk({tag, "_wb_valid"}, 32'(bus_if.WB_Valid), 32'h0);
      chk({tag, "_wb_regwrite"}, 32'(bus_if.WB_RegWrite), 32'h0);
      chk({tag, "_wb_rd"}, 32'(bus_if.WB_RD), 32'h0);
      chk({tag, "_wb_data"}, bus_if.WB_WriteData, 32'h0);
      chk({tag, "_mem_misalign"}, 32'(bus_if.mem_misalign), 32'h0);
      chk({tag, "_bus_err"}, 32'(bus_if.bus_err), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ns;
      int nr;
      reset = 1'b0;
      bus_if.MEM_Valid = 1'b0; bus_if.MEM_ALUResult = '0; bus_if.MEM_D2 = '0;
      bus_if.MEM_RD = '0; bus_if.MEM_RegWrite = 1'b0; bus_if.MEM_MemToReg = 1'b0;
      bus_if.MEM_MEM_WEN = 1'b0; bus_if.MEM_MEM_REN = 1'b0;
      bus_if.dmem_ack = 1'b0; bus_if.dmem_rdata = '0;
      #12;
      check_all_zero("reset");
      @(posedge clock);
      #1 reset = 1'b1;
      idle(2);

      // ALU op: 0x1234 -> r5, one-edge latency, never stalls.
      run_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, ns, nr);
      chk("alu_stall_cycles", 32'(ns), 32'd0);
      @(negedge clock);
      chk("alu_wb_data", bus_if.WB_WriteData, 32'h1234);
      chk("alu_wb_rd", 32'(bus_if.WB_RD), 32'd5);
      idle(1);

      // Back-to-back ALU ops: r0 target suppresses RegWrite; RegWrite=0 passes through.
      run_op(32'hFFFF_0001, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, ns, nr);
      run_op(32'h0000_00A5, 32'h0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, ns, nr);
      idle(2);

      // Load 0x100 -> r8, ack on the fourth BUSY cycle.
      run_op(32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'hDEAD_BEEF, ns, nr);
      chk("load_stall_cycles", 32'(ns), 32'd4);
      @(negedge clock);
      chk("load_wb_data", bus_if.WB_WriteData, 32'hDEAD_BEEF);
      chk("load_wb_regwrite", 32'(bus_if.WB_RegWrite), 32'd1);
      idle(1);

      // Store 0x200, acked in the first BUSY cycle.
      run_op(32'h200, 32'hCAFE_0001, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0, ns, nr);
      chk("store_req_cycles", 32'(nr), 32'd1);
      @(negedge clock);
      chk("store_wb_regwrite", 32'(bus_if.WB_RegWrite), 32'd0);
      idle(1);

      // Misaligned load: no request, single misalign pulse.
      run_op(32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h0, ns, nr);
      chk("misalign_req_cycles", 32'(nr), 32'd0);
      chk("misalign_stall_cycles", 32'(ns), 32'd0);
      @(negedge clock);
      chk("misalign_pulse", 32'(bus_if.mem_misalign), 32'd1);
      idle(1);

      // Load with no ack: times out after T BUSY cycles.
      run_op(32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 99, 32'h0, ns, nr);
      chk("timeout_req_cycles", 32'(nr), 32'd4);
      @(negedge clock);
      chk("timeout_bus_err", 32'(bus_if.bus_err), 32'd1);
      chk("timeout_wb_regwrite", 32'(bus_if.WB_RegWrite), 32'd0);
      idle(1);

      // WEN and REN together: a write, so no register write.
      run_op(32'h44, 32'h1357_9BDF, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1, 32'h2468_ACE0, ns, nr);
      idle(1);

      // Ack on the timeout cycle: ack wins, MemToReg=0 writes the address result.
      run_op(32'h500, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, int'(T) - 1, 32'h0F0F_0F0F, ns, nr);
      idle(1);

      // Stray ack while idle is ignored.
      bus_if.dmem_ack = 1'b1;
      idle(1);
      bus_if.dmem_ack = 1'b0;
      run_op(32'h0000_7777, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, ns, nr);
      idle(1);

      // Reset during the second BUSY cycle abandons the access.
      bus_if.MEM_Valid = 1'b1; bus_if.MEM_ALUResult = 32'h400; bus_if.MEM_D2 = 32'h0;
      bus_if.MEM_RD = 5'd9; bus_if.MEM_RegWrite = 1'b1; bus_if.MEM_MemToReg = 1'b1;
      bus_if.MEM_MEM_WEN = 1'b0; bus_if.MEM_MEM_REN = 1'b1;
      exp_stall = 1'b1;
      @(posedge clock);
      #1;
      exp_we = 1'b0; exp_addr = 32'h400; exp_wdata = 32'h0; bus_active = 1'b1;
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check_all_zero("busy_reset");
      bus_active = 1'b0;
      exp_stall  = 1'b0;
      bus_if.MEM_Valid = 1'b0; bus_if.MEM_MEM_REN = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      idle(4);

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
